orb_uart_pkt_rx: RTL and testbench
==================================

Name: orb_uart_pkt_rx

Overview:
- Receive side of the RS485 poll link in the orbital M16 frame path; runs on the 80 MHz domain.
- After the transmit/request window closes (`arm`), it deserialises a fixed-length reply packet from the UART line. Each byte is written into the downstream frame-buffer RAM.
- Ends every packet with exactly one `pkt_valid` or one `pkt_err` pulse, never both.
- Checks byte 0 of each packet as a rolling sequence counter.

Parameters:
- CLKS_PER_BIT, 34, clk80MHz cycles per UART bit (≈420 ns bit).
- PKT_LEN, 20, bytes per reply packet.
- ADDR_W, 5, width of `wr_addr`; must satisfy 2^ADDR_W >= PKT_LEN.
- TO_FIRST, 4096, max cycles from `arm` to the first start-bit edge.
- TO_GAP, 1024, max cycles from a stop-bit sample to the next start-bit edge.

Ports:
- clk80MHz  in  1  system clock, 80 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input, asynchronous; idle high.
- arm  in  1  1-cycle pulse: request window ended, expect a reply.
- wr_en  out  1  1-cycle byte write strobe.
- wr_addr  out  ADDR_W  byte index within the packet, 0..PKT_LEN-1.
- wr_data  out  8  received byte.
- pkt_valid  out  1  1-cycle pulse: all PKT_LEN bytes received.
- pkt_err  out  1  1-cycle pulse: packet aborted.
- err_code  out  2  cause, held until next `arm`: 0 none, 1 timeout, 2 framing (bad stop bit), 3 re-armed while busy.
- seq_gap  out  1  valid with `pkt_valid`: byte 0 != previous byte 0 + 1 (mod 256).
- busy  out  1  high from `arm` until the `pkt_valid`/`pkt_err` cycle inclusive.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; FSM=IDLE; byte index 0; sequence history invalid.
- `rx` passes through a 2-FF synchroniser, reset value 1. All sampling uses the synchronised signal; a start edge is detected as its high→low transition.
- FSM states: IDLE, WAIT_START, START, DATA, STOP.
- IDLE: `arm` → WAIT_START; timeout counter loaded with TO_FIRST; index 0; `err_code` cleared.
- WAIT_START: counter decrements every cycle.
  - Start edge → START with bit counter = CLKS_PER_BIT/2.
  - Counter reaches 0 → `pkt_err`, `err_code`=1, go to IDLE.
- START: at half-bit, sample.
  - If low → DATA.
  - If high (glitch) → back to WAIT_START; the timeout counter is not reloaded.
- DATA: 8 samples at full-bit intervals, LSB first, shifted into a byte register.
- STOP: one full bit later, sample.
  - High: `wr_en`=1 for one cycle with `wr_addr`=index and `wr_data`=byte.
    - If index = PKT_LEN-1: `pkt_valid` pulses in the same cycle, then IDLE.
    - Otherwise: index+1, then WAIT_START with the counter loaded with TO_GAP.
  - Low: no write, `pkt_err`, `err_code`=2, go to IDLE.
- Latency: `wr_en` is asserted 1 cycle after the stop-bit mid-sample, which itself occurs 9.5 bit periods after the detected start edge (+2 synchroniser cycles).
- `arm` while busy: current packet is discarded, `pkt_err` pulses, `err_code`=3. Same cycle: restart as from IDLE; `busy` stays high and `err_code` remains 3 until the next `arm`.
- Sequence check:
  - On the `pkt_valid` cycle, `seq_gap` = (history valid) && (byte0 != last_byte0+1), with 8-bit wrap: 255→0 is OK.
  - History updates only on `pkt_valid`; an errored packet does not update it.
  - First packet after reset gives `seq_gap`=0.
- Bytes already written in a packet that later errors stay in RAM; the consumer qualifies RAM contents only by `pkt_valid`.
- `rx` activity while IDLE is ignored.

Test Plan:
- Reset, `arm`, 30 bit-times idle, then 20 bytes (5, 10, 20 … 190), 10-bit idle gaps → 20 `wr_en` with addr 0..19 and matching data; `pkt_valid` at the last write; `seq_gap`=0; `err_code`=0.
- Second packet with byte0=6 → `seq_gap`=0. Third packet with byte0=9 → `seq_gap`=1. Then byte0=255 followed by byte0=0 → `seq_gap`=0.
- `arm`, no `rx` activity → `pkt_err` exactly TO_FIRST cycles after `arm`; `err_code`=1; no `wr_en`.
- Stop bit of byte 7 driven low → 7 writes (addr 0..6), then `pkt_err` with `err_code`=2; the next packet's byte0 is checked against the last good packet's byte0.
- 3-cycle low glitch on `rx` in WAIT_START, then a valid packet → glitch ignored; 20 writes; `pkt_valid`.
- `arm` during byte 4 → `pkt_err` with `err_code`=3 and `busy` held high; the following full packet completes with addr restarting at 0. Separately, asserting `rst_n` low mid-byte clears all outputs immediately.

Source files
------------

// File: rtl/orb_uart_pkt_rx.sv
`timescale 1ns/1ps
// Reply-packet receiver for the M16 RS485 poll link: after `arm` it deserialises
// PKT_LEN UART bytes into the frame-buffer RAM and tracks the byte-0 sequence counter.
module orb_uart_pkt_rx #(
  parameter int CLKS_PER_BIT = 34,
  parameter int PKT_LEN      = 20,
  parameter int ADDR_W       = 5,
  parameter int TO_FIRST     = 4096,
  parameter int TO_GAP       = 1024
) (
  input  logic              clk80MHz,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              arm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              pkt_valid,
  output logic              pkt_err,
  output logic [1:0]        err_code,
  output logic              seq_gap,
  output logic              busy
);
  localparam int TO_MAX = (TO_FIRST > TO_GAP) ? TO_FIRST : TO_GAP;
  localparam int TO_W   = $clog2(TO_MAX + 1);
  localparam int BC_W   = $clog2(CLKS_PER_BIT + 1);

  localparam logic [TO_W-1:0]   TO_FIRST_L = TO_W'(TO_FIRST);
  localparam logic [TO_W-1:0]   TO_GAP_L   = TO_W'(TO_GAP);
  localparam logic [TO_W-1:0]   TO_ONE     = TO_W'(1);
  localparam logic [BC_W-1:0]   BC_FULL    = BC_W'(CLKS_PER_BIT);
  localparam logic [BC_W-1:0]   BC_HALF    = BC_W'(CLKS_PER_BIT / 2);
  localparam logic [BC_W-1:0]   BC_ONE     = BC_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(PKT_LEN - 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_FRAME   = 2'd2;
  localparam logic [1:0] ERR_REARM   = 2'd3;

  typedef enum logic [2:0] {IDLE, WAIT_START, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic              rst_q, rst_n_s;
  logic              rx_p0, rx_p1, rx_p2;
  logic              start_edge, bit_tick;
  logic [TO_W-1:0]   to_cnt, to_nxt;
  logic [BC_W-1:0]   bit_cnt, bc_nxt;
  logic [2:0]        nbit, nbit_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic [7:0]        shreg, b0_cur, last_b0, b0_now;
  logic              hist_vld, hist_upd, shift_en;
  logic              wr_en_nxt, valid_nxt, err_nxt, gap_nxt, busy_nxt;
  logic [1:0]        code_nxt;

  function automatic logic seq_break(input logic hist, input logic [7:0] prev,
                                     input logic [7:0] cur);
    logic [7:0] want;
    want = prev + 8'd1;
    return hist && (cur != want);
  endfunction

  // Reset: asserts asynchronously, releases on a clock edge.
  always_ff @(posedge clk80MHz or negedge rst_n) begin
    if (!rst_n) begin
      rst_q   <= 1'b0;
      rst_n_s <= 1'b0;
    end else begin
      rst_q   <= 1'b1;
      rst_n_s <= rst_q;
    end
  end

  // p0/p1: rx synchroniser; p2: previous synchronised sample for edge detection.
  always_ff @(posedge clk80MHz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign start_edge = rx_p2 & ~rx_p1;
  assign bit_tick   = (bit_cnt == BC_ONE);
  assign b0_now     = (idx == '0) ? shreg : b0_cur;

  always_comb begin
    state_nxt = state;
    to_nxt    = to_cnt;
    bc_nxt    = bit_cnt;
    nbit_nxt  = nbit;
    idx_nxt   = idx;
    code_nxt  = err_code;
    wr_en_nxt = 1'b0;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    gap_nxt   = 1'b0;
    shift_en  = 1'b0;
    hist_upd  = 1'b0;
    case (state)
      WAIT_START: begin
        if (start_edge) begin
          state_nxt = START;
          bc_nxt    = BC_HALF;
        end else if (to_cnt == TO_ONE) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          code_nxt  = ERR_TIMEOUT;
        end else begin
          to_nxt = to_cnt - 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          if (!rx_p1) begin
            state_nxt = DATA;
            bc_nxt    = BC_FULL;
            nbit_nxt  = '0;
          end else begin
            // A start pulse shorter than half a bit is noise; keep the original deadline.
            state_nxt = WAIT_START;
          end
        end else begin
          bc_nxt = bit_cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_en = 1'b1;
          bc_nxt   = BC_FULL;
          if (nbit == 3'd7) state_nxt = STOP;
          else              nbit_nxt  = nbit + 1'b1;
        end else begin
          bc_nxt = bit_cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (rx_p1) begin
            wr_en_nxt = 1'b1;
            if (idx == LAST_IDX) begin
              valid_nxt = 1'b1;
              gap_nxt   = seq_break(hist_vld, last_b0, b0_now);
              hist_upd  = 1'b1;
              state_nxt = IDLE;
            end else begin
              idx_nxt   = idx + 1'b1;
              to_nxt    = TO_GAP_L;
              state_nxt = WAIT_START;
            end
          end else begin
            err_nxt   = 1'b1;
            code_nxt  = ERR_FRAME;
            state_nxt = IDLE;
          end
        end else begin
          bc_nxt = bit_cnt - 1'b1;
        end
      end
      default: ;
    endcase
    // A new request always wins: any packet in flight is dropped without a write.
    if (arm) begin
      if (state != IDLE) begin
        err_nxt  = 1'b1;
        code_nxt = ERR_REARM;
      end else begin
        code_nxt = ERR_NONE;
      end
      wr_en_nxt = 1'b0;
      valid_nxt = 1'b0;
      gap_nxt   = 1'b0;
      hist_upd  = 1'b0;
      state_nxt = WAIT_START;
      to_nxt    = TO_FIRST_L;
      idx_nxt   = '0;
    end
    busy_nxt = (state_nxt != IDLE) || valid_nxt || err_nxt;
  end

  always_ff @(posedge clk80MHz or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state     <= IDLE;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      nbit      <= '0;
      idx       <= '0;
      hist_vld  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
      seq_gap   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      to_cnt    <= to_nxt;
      bit_cnt   <= bc_nxt;
      nbit      <= nbit_nxt;
      idx       <= idx_nxt;
      wr_en     <= wr_en_nxt;
      pkt_valid <= valid_nxt;
      pkt_err   <= err_nxt;
      err_code  <= code_nxt;
      seq_gap   <= gap_nxt;
      busy      <= busy_nxt;
      if (wr_en_nxt) begin
        wr_addr <= idx;
        wr_data <= shreg;
      end
      if (hist_upd) hist_vld <= 1'b1;
    end
  end

  // Byte datapath: only qualified by the control above, so it carries no reset.
  always_ff @(posedge clk80MHz) begin
    if (shift_en) shreg <= {rx_p1, shreg[7:1]};
    if (wr_en_nxt && (idx == '0)) b0_cur <= shreg;
    if (hist_upd) last_b0 <= b0_now;
  end

endmodule

// File: tb/tb_orb_uart_pkt_rx.sv
`timescale 1ns/1ps
// Directed bench for orb_uart_pkt_rx: packet reception, sequence check, timeout,
// framing error, start glitch, re-arm while busy and asynchronous reset.
module tb_orb_uart_pkt_rx;
  localparam int CPB  = 34;
  localparam int PLEN = 20;
  localparam int AW   = 5;
  localparam int TOF  = 4096;
  localparam int TOG  = 1024;

  logic          clk80MHz = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          arm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          pkt_valid;
  logic          pkt_err;
  logic [1:0]    err_code;
  logic          seq_gap;
  logic          busy;

  orb_uart_pkt_rx #(
    .CLKS_PER_BIT(CPB), .PKT_LEN(PLEN), .ADDR_W(AW), .TO_FIRST(TOF), .TO_GAP(TOG)
  ) dut (
    .clk80MHz (clk80MHz),
    .rst_n    (rst_n),
    .rx       (rx),
    .arm      (arm),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pkt_valid(pkt_valid),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .seq_gap  (seq_gap),
    .busy     (busy)
  );

  always #6 clk80MHz = ~clk80MHz;

  // Event recorder (written only here, read by the stimulus block).
  int            n_wr = 0;
  int            n_val = 0;
  int            n_err = 0;
  int            n_both = 0;
  logic [AW-1:0] log_addr [0:255];
  logic [7:0]    log_data [0:255];
  logic          v_gap = 1'b0, v_wr = 1'b0, e_busy = 1'b0, e_busy_post = 1'b0, err_q = 1'b0;
  logic [AW-1:0] v_addr = '0;
  logic [1:0]    v_code = '0, e_code = '0;

  always @(negedge clk80MHz) begin
    if (err_q) e_busy_post = busy;
    err_q = pkt_err;
    if (wr_en) begin
      log_addr[n_wr[7:0]] = wr_addr;
      log_data[n_wr[7:0]] = wr_data;
      n_wr++;
    end
    if (pkt_valid) begin
      n_val++;
      v_gap  = seq_gap;
      v_wr   = wr_en;
      v_addr = wr_addr;
      v_code = err_code;
    end
    if (pkt_err) begin
      n_err++;
      e_code = err_code;
      e_busy = busy;
    end
    if (pkt_valid && pkt_err) n_both++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int bw, bv, be, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input logic [7:0] b0);
    return (i == 0) ? b0 : 8'(10 * i);
  endfunction

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    repeat (nb * CPB) @(negedge clk80MHz);
  endtask

  // Drives one 8N1 frame; arm pulses for one cycle at frame cycle arm_at (if >= 0).
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int arm_at);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int c = 0; c < 10 * CPB; c++) begin
      rx  = frame[c / CPB];
      arm = (c == arm_at);
      @(negedge clk80MHz);
    end
    rx  = 1'b1;
    arm = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input int nbytes, input int bad_stop,
                          input int lead, input int gap);
    idle_bits(lead);
    for (int i = 0; i < nbytes; i++) begin
      send_byte(pat(i, b0), (i != bad_stop), -1);
      if (gap > 0) idle_bits(gap);
    end
    idle_bits(2);
  endtask

  task automatic pulse_arm();
    @(negedge clk80MHz);
    arm = 1'b1;
    @(negedge clk80MHz);
    arm = 1'b0;
  endtask

  task automatic run_pkt(input logic [7:0] b0, input logic exp_gap, input logic [1:0] exp_code,
                         input logic do_arm, input int lead, input int gap);
    int w0, v0;
    w0 = n_wr;
    v0 = n_val;
    if (do_arm) pulse_arm();
    send_pkt(b0, PLEN, -1, lead, gap);
    chk("pkt_wr_count", n_wr - w0, PLEN);
    for (int i = 0; i < PLEN; i++) begin
      chk("pkt_wr_addr", log_addr[8'(w0 + i)], i);
      chk("pkt_wr_data", log_data[8'(w0 + i)], pat(i, b0));
    end
    chk("pkt_valid_count", n_val - v0, 1);
    chk("pkt_valid_with_wr", v_wr, 1);
    chk("pkt_valid_addr", v_addr, PLEN - 1);
    chk("pkt_seq_gap", v_gap, exp_gap);
    chk("pkt_err_code", v_code, exp_code);
    chk("pkt_busy_after", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    arm   = 1'b0;
    repeat (3) @(negedge clk80MHz);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_seq_gap", seq_gap, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk80MHz);

    // Sequence: 5 (first), 6, 9 (jump), 255 (jump), 0 (wrap).
    run_pkt(8'd5, 1'b0, 2'd0, 1'b1, 30, 10);
    run_pkt(8'd6, 1'b0, 2'd0, 1'b1, 2, 0);
    run_pkt(8'd9, 1'b1, 2'd0, 1'b1, 2, 0);
    run_pkt(8'd255, 1'b1, 2'd0, 1'b1, 2, 0);
    run_pkt(8'd0, 1'b0, 2'd0, 1'b1, 2, 0);

    // Timeout with a silent line.
    bw = n_wr;
    be = n_err;
    @(negedge clk80MHz);
    arm = 1'b1;
    @(negedge clk80MHz);
    arm = 1'b0;
    n = 0;
    while ((n < TOF + 50) && !pkt_err) begin
      @(negedge clk80MHz);
      n++;
    end
    chk("to_cycles", n, TOF);
    repeat (3) @(negedge clk80MHz);
    chk("to_err_count", n_err - be, 1);
    chk("to_err_code", e_code, 1);
    chk("to_no_wr", n_wr - bw, 0);
    chk("to_busy_at_err", e_busy, 1);
    chk("to_busy_after", e_busy_post, 0);

    // Bad stop bit on byte 7.
    bw = n_wr;
    bv = n_val;
    be = n_err;
    pulse_arm();
    send_pkt(8'd50, 8, 7, 2, 0);
    chk("frm_wr_count", n_wr - bw, 7);
    for (int i = 0; i < 7; i++) begin
      chk("frm_wr_addr", log_addr[8'(bw + i)], i);
      chk("frm_wr_data", log_data[8'(bw + i)], pat(i, 8'd50));
    end
    chk("frm_err_count", n_err - be, 1);
    chk("frm_err_code", e_code, 2);
    chk("frm_no_valid", n_val - bv, 0);

    // Short low glitch while waiting; byte0 1 follows the last good 0.
    be = n_err;
    pulse_arm();
    idle_bits(5);
    rx = 1'b0;
    repeat (3) @(negedge clk80MHz);
    rx = 1'b1;
    run_pkt(8'd1, 1'b0, 2'd0, 1'b0, 5, 0);
    chk("glitch_no_err", n_err - be, 0);

    // Re-arm during byte 4 (0xF0: line stays high after bit 3, so no stray start edge).
    bw = n_wr;
    be = n_err;
    pulse_arm();
    idle_bits(2);
    for (int i = 0; i < 4; i++) send_byte(pat(i, 8'd40), 1'b1, -1);
    send_byte(8'hF0, 1'b1, 6 * CPB + 5);
    chk("rearm_wr_count", n_wr - bw, 4);
    chk("rearm_err_count", n_err - be, 1);
    chk("rearm_err_code", e_code, 3);
    chk("rearm_busy_at_err", e_busy, 1);
    chk("rearm_busy_after", e_busy_post, 1);
    run_pkt(8'd2, 1'b0, 2'd3, 1'b0, 2, 0);

    // Asynchronous reset in the middle of byte 2.
    pulse_arm();
    idle_bits(2);
    send_byte(8'd77, 1'b1, -1);
    send_byte(8'd10, 1'b1, -1);
    rx = 1'b0;
    repeat (50) @(negedge clk80MHz);
    chk("prerst_busy", busy, 1);
    chk("prerst_wr_addr", wr_addr, 1);
    chk("prerst_wr_data", wr_data, 10);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_wr_en", wr_en, 0);
    chk("arst_err_code", err_code, 0);
    chk("arst_pkt_valid", pkt_valid, 0);
    chk("arst_pkt_err", pkt_err, 0);
    repeat (4) @(negedge clk80MHz);
    rx    = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk80MHz);
    // History cleared by reset: 200 after last good 2 is not a gap.
    run_pkt(8'd200, 1'b0, 2'd0, 1'b1, 2, 0);

    chk("never_valid_and_err", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
